// File: rtl/datapath_pipe.sv
// Pipelined CPU datapath front end: PC, IF/ID and ID/EX registers with stall,
// fetch-valid handling and branch/jump redirect that kills the two younger stages.
module datapath_pipe #(
   parameter int              DW     = 16,
   parameter int              PC_INC = 2,
   parameter logic [DW-1:0]   RST_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   output logic [DW-1:0] imem_addr,
   input  logic [15:0]   imem_rdata,
   input  logic          imem_valid,
   input  logic          stall,
   input  logic [1:0]    addrbase,
   input  logic          mulreg,
   input  logic          alusrc,
   input  logic [DW-1:0] ext_imm,
   input  logic [DW-1:0] rdata1,
   input  logic [DW-1:0] rdata2,
   input  logic          br_taken,
   input  logic          jump,
   input  logic          mem_alu,
   input  logic          insdat,
   input  logic [DW-1:0] rwdata,
   input  logic [DW-1:0] result,
   output logic [4:0]    opcode,
   output logic [2:0]    func,
   output logic [6:0]    offset,
   output logic          rdest_bit0,
   output logic [3:0]    addr1,
   output logic [3:0]    addr2,
   output logic          id_valid,
   output logic          ex_valid,
   output logic [DW-1:0] ex_var1,
   output logic [DW-1:0] ex_var2,
   output logic [DW-1:0] ex_wmdata,
   output logic [DW-1:0] ex_br_tgt,
   output logic [DW-1:0] ex_jmp_tgt,
   output logic [DW-1:0] wrfdata,
   output logic [DW-1:0] addrm
);

   logic [DW-1:0] pc_q, pc_d;
   logic [15:0]   id_instr_q, id_instr_d;
   logic [DW-1:0] id_pc_plus_q, id_pc_plus_d;
   logic          id_valid_q, id_valid_d;
   logic          ex_valid_q, ex_valid_d;
   logic [DW-1:0] ex_var1_q, ex_var1_d;
   logic [DW-1:0] ex_var2_q, ex_var2_d;
   logic [DW-1:0] ex_wmdata_q, ex_wmdata_d;
   logic [DW-1:0] ex_br_tgt_q, ex_br_tgt_d;
   logic [DW-1:0] ex_jmp_tgt_q, ex_jmp_tgt_d;

   logic          redirect;
   logic [DW-1:0] redirect_tgt;
   logic [DW-1:0] pc_inc;

   assign pc_inc       = pc_q + DW'(PC_INC);
   // A branch/jump only counts when a real instruction sits in E; jump beats branch.
   assign redirect     = ex_valid_q & (br_taken | jump);
   assign redirect_tgt = jump ? ex_jmp_tgt_q : ex_br_tgt_q;

   always_comb begin : next_state
      // NOTE: every _d starts from its held value so no path leaves it unassigned (no latch).
      pc_d         = pc_q;
      id_instr_d   = id_instr_q;
      id_pc_plus_d = id_pc_plus_q;
      id_valid_d   = id_valid_q;
      ex_valid_d   = 1'b0;
      ex_var1_d    = ex_var1_q;
      ex_var2_d    = ex_var2_q;
      ex_wmdata_d  = ex_wmdata_q;
      ex_br_tgt_d  = ex_br_tgt_q;
      ex_jmp_tgt_d = ex_jmp_tgt_q;

      if (redirect) begin
         pc_d       = redirect_tgt;
         id_valid_d = 1'b0;
      end else if (!stall) begin
         if (imem_valid) begin
            pc_d         = pc_inc;
            id_instr_d   = imem_rdata;
            id_pc_plus_d = pc_inc;
            id_valid_d   = 1'b1;
         end else begin
            id_valid_d   = 1'b0;
         end
      end

      if (!redirect && !stall && id_valid_q) begin
         ex_valid_d   = 1'b1;
         ex_var1_d    = rdata1;
         ex_var2_d    = alusrc ? rdata2 : ext_imm;
         ex_wmdata_d  = rdata2;
         ex_br_tgt_d  = id_pc_plus_q + ext_imm;
         ex_jmp_tgt_d = {id_pc_plus_q[DW-1:14], id_instr_q[12:0], 1'b0};
      end
   end

   // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RST_PC;
         id_instr_q   <= '0;
         id_pc_plus_q <= '0;
         id_valid_q   <= 1'b0;
         ex_valid_q   <= 1'b0;
         ex_var1_q    <= '0;
         ex_var2_q    <= '0;
         ex_wmdata_q  <= '0;
         ex_br_tgt_q  <= '0;
         ex_jmp_tgt_q <= '0;
      end else begin
         pc_q         <= pc_d;
         id_instr_q   <= id_instr_d;
         id_pc_plus_q <= id_pc_plus_d;
         id_valid_q   <= id_valid_d;
         ex_valid_q   <= ex_valid_d;
         ex_var1_q    <= ex_var1_d;
         ex_var2_q    <= ex_var2_d;
         ex_wmdata_q  <= ex_wmdata_d;
         ex_br_tgt_q  <= ex_br_tgt_d;
         ex_jmp_tgt_q <= ex_jmp_tgt_d;
      end
   end

   assign opcode     = id_instr_q[15:11];
   assign func       = id_instr_q[2:0];
   assign offset     = id_instr_q[6:0];
   assign rdest_bit0 = id_instr_q[7];
   assign addr2      = {id_instr_q[10:8], mulreg};

   always_comb begin : addr1_mux
      case (addrbase)
         2'd0:    addr1 = 4'd0;
         2'd2:    addr1 = addr2;
         default: addr1 = id_instr_q[6:3];
      endcase
   end

   assign imem_addr  = pc_q;
   assign id_valid   = id_valid_q;
   assign ex_valid   = ex_valid_q;
   assign ex_var1    = ex_var1_q;
   assign ex_var2    = ex_var2_q;
   assign ex_wmdata  = ex_wmdata_q;
   assign ex_br_tgt  = ex_br_tgt_q;
   assign ex_jmp_tgt = ex_jmp_tgt_q;
   assign wrfdata    = mem_alu ? rwdata : result;
   assign addrm      = insdat ? result : pc_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: directed scenario with literal expectations plus a
// per-cycle comparison against a stage-record model of the pipeline.
module tb_datapath_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] imem_addr, imem_rdata;
   logic        imem_valid, stall;
   logic [1:0]  addrbase;
   logic        mulreg, alusrc;
   logic [15:0] ext_imm, rdata1, rdata2;
   logic        br_taken, jump, mem_alu, insdat;
   logic [15:0] rwdata, result;
   logic [4:0]  opcode;
   logic [2:0]  func;
   logic [6:0]  offset;
   logic        rdest_bit0;
   logic [3:0]  addr1, addr2;
   logic        id_valid, ex_valid;
   logic [15:0] ex_var1, ex_var2, ex_wmdata, ex_br_tgt, ex_jmp_tgt, wrfdata, addrm;

   datapath_pipe dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_valid(imem_valid), .stall(stall), .addrbase(addrbase), .mulreg(mulreg),
      .alusrc(alusrc), .ext_imm(ext_imm), .rdata1(rdata1), .rdata2(rdata2),
      .br_taken(br_taken), .jump(jump), .mem_alu(mem_alu), .insdat(insdat),
      .rwdata(rwdata), .result(result), .opcode(opcode), .func(func), .offset(offset),
      .rdest_bit0(rdest_bit0), .addr1(addr1), .addr2(addr2), .id_valid(id_valid),
      .ex_valid(ex_valid), .ex_var1(ex_var1), .ex_var2(ex_var2), .ex_wmdata(ex_wmdata),
      .ex_br_tgt(ex_br_tgt), .ex_jmp_tgt(ex_jmp_tgt), .wrfdata(wrfdata), .addrm(addrm)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic [15:0] instr;
      logic [15:0] pc_plus;
   } id_t;

   typedef struct packed {
      logic        v;
      logic [15:0] var1;
      logic [15:0] var2;
      logic [15:0] wm;
      logic [15:0] br;
      logic [15:0] jmp;
   } ex_t;

   logic [15:0] m_pc;
   id_t         m_id;
   ex_t         m_ex;
   logic        cmp_en = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic logic [15:0] imem_fn(input logic [15:0] a);
      if (a == 16'hC000) return 16'h0123;
      return (a * 16'h1357) ^ 16'hA5C3;
   endfunction

   function automatic logic [15:0] rf1(input logic [3:0] a);
      return {a, a ^ 4'hF, 4'h1, a};
   endfunction

   function automatic logic [15:0] rf2(input logic [3:0] a);
      return {4'h8, a, ~a, a ^ 4'h5};
   endfunction

   function automatic logic [3:0] f_addr2(input logic [15:0] ins, input logic mr);
      return {ins[10:8], mr};
   endfunction

   function automatic logic [3:0] f_addr1(input logic [15:0] ins, input logic [1:0] ab,
                                          input logic mr);
      if (ab == 2'd0) return 4'd0;
      if (ab == 2'd2) return f_addr2(ins, mr);
      return ins[6:3];
   endfunction

   // Instruction memory and register file respond to the addresses the model expects.
   assign imem_rdata = imem_fn(imem_addr);
   assign rdata1     = rf1(f_addr1(m_id.instr, addrbase, mulreg));
   assign rdata2     = rf2(f_addr2(m_id.instr, mulreg));

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs held over the edge.
   task automatic step();
      logic [15:0] n_pc;
      id_t         n_id;
      ex_t         n_ex;
      logic        redir;
      if (rst) begin
         n_pc = 16'h0000;
         n_id = '0;
         n_ex = '0;
      end else begin
         n_pc   = m_pc;
         n_id   = m_id;
         n_ex   = m_ex;
         n_ex.v = 1'b0;
         redir  = m_ex.v && (br_taken || jump);
         if (redir) begin
            n_pc   = jump ? m_ex.jmp : m_ex.br;
            n_id.v = 1'b0;
         end else if (!stall) begin
            if (imem_valid) begin
               n_id.v       = 1'b1;
               n_id.instr   = imem_fn(m_pc);
               n_id.pc_plus = m_pc + 16'd2;
               n_pc         = m_pc + 16'd2;
            end else begin
               n_id.v = 1'b0;
            end
         end
         if (!redir && !stall && m_id.v) begin
            n_ex.v    = 1'b1;
            n_ex.var1 = rf1(f_addr1(m_id.instr, addrbase, mulreg));
            n_ex.var2 = alusrc ? rf2(f_addr2(m_id.instr, mulreg)) : ext_imm;
            n_ex.wm   = rf2(f_addr2(m_id.instr, mulreg));
            n_ex.br   = m_id.pc_plus + ext_imm;
            n_ex.jmp  = {m_id.pc_plus[15:14], m_id.instr[12:0], 1'b0};
         end
      end
      @(posedge clk);
      #1;
      m_pc   = n_pc;
      m_id   = n_id;
      m_ex   = n_ex;
      cmp_en = 1'b1;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("imem_addr", imem_addr, m_pc);
         check("id_valid", 16'(id_valid), 16'(m_id.v));
         check("ex_valid", 16'(ex_valid), 16'(m_ex.v));
         check("wrfdata", wrfdata, mem_alu ? rwdata : result);
         check("addrm", addrm, insdat ? result : m_pc);
         if (m_id.v) begin
            check("opcode", 16'(opcode), 16'(m_id.instr[15:11]));
            check("func", 16'(func), 16'(m_id.instr[2:0]));
            check("offset", 16'(offset), 16'(m_id.instr[6:0]));
            check("rdest_bit0", 16'(rdest_bit0), 16'(m_id.instr[7]));
            check("addr1", 16'(addr1), 16'(f_addr1(m_id.instr, addrbase, mulreg)));
            check("addr2", 16'(addr2), 16'(f_addr2(m_id.instr, mulreg)));
         end
         if (m_ex.v) begin
            check("ex_var1", ex_var1, m_ex.var1);
            check("ex_var2", ex_var2, m_ex.var2);
            check("ex_wmdata", ex_wmdata, m_ex.wm);
            check("ex_br_tgt", ex_br_tgt, m_ex.br);
            check("ex_jmp_tgt", ex_jmp_tgt, m_ex.jmp);
         end
      end
   end

   initial begin
      rst = 1'b1; imem_valid = 1'b0; stall = 1'b0; br_taken = 1'b0; jump = 1'b0;
      addrbase = 2'd1; mulreg = 1'b0; alusrc = 1'b1; ext_imm = 16'h003C;
      mem_alu = 1'b0; insdat = 1'b0; rwdata = 16'h1234; result = 16'h5678;
      m_pc = '0; m_id = '0; m_ex = '0;

      step();
      check("rst_pc", imem_addr, 16'h0000);
      check("rst_id_valid", 16'(id_valid), 16'h0);
      check("rst_ex_valid", 16'(ex_valid), 16'h0);

      rst = 1'b0; imem_valid = 1'b1;
      step();
      check("seq_pc2", imem_addr, 16'h0002);
      check("seq_id_valid", 16'(id_valid), 16'h1);
      check("seq_ex_valid0", 16'(ex_valid), 16'h0);
      step();
      check("seq_pc4", imem_addr, 16'h0004);
      check("seq_ex_valid1", 16'(ex_valid), 16'h1);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_pc", imem_addr, 16'h0004);
         check("stall_ex_bubble", 16'(ex_valid), 16'h0);
         check("stall_id_hold", 16'(opcode), 16'(imem_fn(16'h0002) >> 11));
      end
      stall = 1'b0;
      step();
      check("resume_pc", imem_addr, 16'h0006);
      check("br_tgt_0040", ex_br_tgt, 16'h0040);

      br_taken = 1'b1;
      step();
      check("branch_pc", imem_addr, 16'h0040);
      check("branch_kill_id", 16'(id_valid), 16'h0);
      check("branch_kill_ex", 16'(ex_valid), 16'h0);
      br_taken = 1'b0;
      step();
      ext_imm = 16'hBFBE;
      step();
      check("br_tgt_c000", ex_br_tgt, 16'hC000);

      br_taken = 1'b1; stall = 1'b1;
      step();
      check("redir_over_stall_pc", imem_addr, 16'hC000);
      check("redir_over_stall_id", 16'(id_valid), 16'h0);
      br_taken = 1'b0; stall = 1'b0;
      step();
      step();
      check("jmp_tgt_c246", ex_jmp_tgt, 16'hC246);
      jump = 1'b1;
      step();
      check("jump_pc", imem_addr, 16'hC246);
      jump = 1'b0;
      step();
      ext_imm = 16'h3DB6;
      step();
      check("br_tgt_fffe", ex_br_tgt, 16'hFFFE);
      br_taken = 1'b1;
      step();
      check("pc_fffe", imem_addr, 16'hFFFE);
      br_taken = 1'b0; jump = 1'b1;
      step();
      check("pc_wrap_jump_ignored", imem_addr, 16'h0000);
      jump = 1'b0; imem_valid = 1'b0;
      step();
      check("no_fetch_pc_hold", imem_addr, 16'h0000);
      check("no_fetch_id_bubble", 16'(id_valid), 16'h0);

      imem_valid = 1'b1;
      step();
      step();
      rst = 1'b1;
      step();
      check("midrst_pc", imem_addr, 16'h0000);
      check("midrst_id_valid", 16'(id_valid), 16'h0);
      check("midrst_ex_valid", 16'(ex_valid), 16'h0);
      rst = 1'b0;

      for (int i = 0; i < 80; i++) begin
         rst        = ($urandom_range(0, 40) == 0);
         stall      = ($urandom_range(0, 3) == 0);
         imem_valid = ($urandom_range(0, 4) != 0);
         br_taken   = ($urandom_range(0, 5) == 0);
         jump       = ($urandom_range(0, 7) == 0);
         addrbase   = 2'($urandom_range(0, 3));
         mulreg     = 1'($urandom_range(0, 1));
         alusrc     = 1'($urandom_range(0, 1));
         mem_alu    = 1'($urandom_range(0, 1));
         insdat     = 1'($urandom_range(0, 1));
         ext_imm    = 16'($urandom);
         rwdata     = 16'($urandom);
         result     = 16'($urandom);
         step();
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
